// File: rtl/ram_arbiter.sv
// Round-robin arbiter between two requesters sharing a single-port data RAM.
// Grants at most one access per cycle, drives the RAM command pins for the
// winner and routes read data back to the owning requester one cycle later.
// A bounded lock lets the winner keep priority for read-modify-write runs.
module ram_arbiter #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_r_w,
    output logic              ram_enable,
    output logic              ram_ce,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(LOCK_MAX - 1);

    // prio_q: 0 = A first, 1 = B first
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             pend_a_q, pend_a_d;
    logic             pend_b_q, pend_b_d;
    logic             win_a, win_b, win_lock;

    // Winner selection; rst_n gating keeps grants and RAM pins quiet in reset.
    always_comb begin
        win_a = rst_n & a_req & (~b_req | ~prio_q);
        win_b = rst_n & b_req & (~a_req |  prio_q);
    end

    // Next-state for priority, lock counter and read-return flags.
    always_comb begin
        prio_d     = prio_q;
        lock_cnt_d = '0;
        win_lock   = 1'b0;
        pend_a_d   = win_a & ~a_we;
        pend_b_d   = win_b & ~b_we;
        if (win_a || win_b) begin
            win_lock = win_a ? a_lock : b_lock;
            if (win_lock && (lock_cnt_q < CntLast)) begin
                prio_d     = win_b;
                lock_cnt_d = lock_cnt_q + 1'b1;
            end else begin
                // Hand priority to the requester that did not just win.
                prio_d     = win_a;
                lock_cnt_d = '0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            lock_cnt_q <= '0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            lock_cnt_q <= lock_cnt_d;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
        end
    end

    // RAM command mux and response routing.
    always_comb begin
        ram_add     = '0;
        ram_data_in = '0;
        ram_r_w     = 1'b0;
        ram_enable  = 1'b0;
        ram_ce      = 1'b0;
        if (win_a) begin
            ram_add     = a_addr;
            ram_data_in = a_wdata;
            ram_r_w     = a_we;
            ram_enable  = 1'b1;
            ram_ce      = 1'b1;
        end else if (win_b) begin
            ram_add     = b_addr;
            ram_data_in = b_wdata;
            ram_r_w     = b_we;
            ram_enable  = 1'b1;
            ram_ce      = 1'b1;
        end
        a_gnt    = win_a;
        b_gnt    = win_b;
        a_rvalid = pend_a_q;
        b_rvalid = pend_b_q;
        a_rdata  = pend_a_q ? ram_data_out : '0;
        b_rdata  = pend_b_q ? ram_data_out : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [5:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [5:0]  ram_add;
    logic [15:0] ram_data_in, ram_data_out;
    logic        ram_r_w, ram_enable, ram_ce;

    int total = 0;
    int bad   = 0;

    ram_arbiter #(
        .ADDR_W  (6),
        .DATA_W  (16),
        .LOCK_MAX(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .a_lock      (a_lock),
        .a_gnt       (a_gnt),
        .a_rvalid    (a_rvalid),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_lock      (b_lock),
        .b_gnt       (b_gnt),
        .b_rvalid    (b_rvalid),
        .b_rdata     (b_rdata),
        .ram_add     (ram_add),
        .ram_data_in (ram_data_in),
        .ram_r_w     (ram_r_w),
        .ram_enable  (ram_enable),
        .ram_ce      (ram_ce),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten locations read back as 0xA000 | addr.
    logic [15:0] mem [64];
    logic [63:0] written = '0;
    always @(posedge clk) begin
        if (ram_enable && ram_ce) begin
            if (ram_r_w) begin
                mem[ram_add]     <= ram_data_in;
                written[ram_add] <= 1'b1;
            end else begin
                ram_data_out <= written[ram_add] ? mem[ram_add] : (16'hA000 | 16'(ram_add));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic ram_idle(input string tag);
        chk({tag, " ram_enable"}, 32'(ram_enable), 0);
        chk({tag, " ram_ce"}, 32'(ram_ce), 0);
        chk({tag, " ram_add"}, 32'(ram_add), 0);
        chk({tag, " ram_data_in"}, 32'(ram_data_in), 0);
        chk({tag, " ram_r_w"}, 32'(ram_r_w), 0);
    endtask

    initial begin
        logic exp_a;
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd9; a_wdata = 16'h5555; a_lock = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'd9; b_wdata = 16'h6666; b_lock = 1'b0;

        // Reset: requests ignored, all outputs low
        settle();
        chk("rst a_gnt", 32'(a_gnt), 0);
        chk("rst b_gnt", 32'(b_gnt), 0);
        chk("rst a_rvalid", 32'(a_rvalid), 0);
        chk("rst b_rvalid", 32'(b_rvalid), 0);
        ram_idle("rst");
        tick();
        tick();
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b1;

        // A write addr 5 = 0x1234, then A read addr 5
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 16'h1234;
        settle();
        chk("wr a_gnt", 32'(a_gnt), 1);
        chk("wr b_gnt", 32'(b_gnt), 0);
        chk("wr ram_enable", 32'(ram_enable), 1);
        chk("wr ram_ce", 32'(ram_ce), 1);
        chk("wr ram_r_w", 32'(ram_r_w), 1);
        chk("wr ram_add", 32'(ram_add), 5);
        chk("wr ram_data_in", 32'(ram_data_in), 32'h1234);
        tick();
        a_we = 1'b0; a_wdata = 16'h0;
        settle();
        chk("rd a_gnt", 32'(a_gnt), 1);
        chk("rd ram_r_w", 32'(ram_r_w), 0);
        chk("rd no rvalid yet", 32'(a_rvalid), 0);
        tick();
        a_req = 1'b0;
        settle();
        chk("rd a_rvalid", 32'(a_rvalid), 1);
        chk("rd a_rdata", 32'(a_rdata), 32'h1234);
        chk("rd b_rvalid", 32'(b_rvalid), 0);
        ram_idle("idle");
        tick();
        settle();
        chk("rvalid one cycle", 32'(a_rvalid), 0);
        chk("rdata zero", 32'(a_rdata), 0);

        // Fresh reset so prio is A, then both read continuously
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd10;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd11;
        for (int k = 0; k < 4; k++) begin
            exp_a = (k % 2 == 0);
            settle();
            chk($sformatf("alt%0d a_gnt", k), 32'(a_gnt), 32'(exp_a));
            chk($sformatf("alt%0d b_gnt", k), 32'(b_gnt), 32'(!exp_a));
            chk($sformatf("alt%0d ram_enable", k), 32'(ram_enable), 1);
            chk($sformatf("alt%0d ram_add", k), 32'(ram_add), exp_a ? 10 : 11);
            if (k > 0) begin
                chk($sformatf("alt%0d a_rvalid", k), 32'(a_rvalid), 32'(!exp_a));
                chk($sformatf("alt%0d a_rdata", k), 32'(a_rdata), exp_a ? 0 : 32'hA00A);
                chk($sformatf("alt%0d b_rvalid", k), 32'(b_rvalid), 32'(exp_a));
                chk($sformatf("alt%0d b_rdata", k), 32'(b_rdata), exp_a ? 32'hA00B : 0);
            end
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        settle();
        chk("alt tail b_rvalid", 32'(b_rvalid), 1);
        chk("alt tail b_rdata", 32'(b_rdata), 32'hA00B);
        chk("alt tail a_rvalid", 32'(a_rvalid), 0);
        tick();

        // Lock: A held 4 grants, B once, then A's count restarts for 4 more
        a_req = 1'b1; a_lock = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_a = (k != 4) && (k != 9);
            settle();
            chk($sformatf("lock%0d a_gnt", k), 32'(a_gnt), 32'(exp_a));
            chk($sformatf("lock%0d b_gnt", k), 32'(b_gnt), 32'(!exp_a));
            tick();
        end
        a_req = 1'b0; a_lock = 1'b0; b_req = 1'b0;
        tick();

        // A writes addr 3 = 0xBEEF, B reads addr 3 next cycle
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd3; a_wdata = 16'hBEEF;
        settle();
        chk("raw a_gnt", 32'(a_gnt), 1);
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd3;
        settle();
        chk("raw b_gnt", 32'(b_gnt), 1);
        tick();
        b_req = 1'b0;
        settle();
        chk("raw b_rvalid", 32'(b_rvalid), 1);
        chk("raw b_rdata", 32'(b_rdata), 32'hBEEF);
        tick();

        // Reset in the cycle after an A read grant; prio (B) must return to A
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd3;
        settle();
        chk("mid a_gnt", 32'(a_gnt), 1);
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'd7; b_wdata = 16'h7777;
        rst_n = 1'b0;
        #1;
        chk("mid a_rvalid", 32'(a_rvalid), 0);
        chk("mid a_rdata", 32'(a_rdata), 0);
        chk("mid b_gnt", 32'(b_gnt), 0);
        ram_idle("mid");
        tick();
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd3;
        b_we = 1'b0; b_addr = 6'd7;
        settle();
        chk("rel a_gnt", 32'(a_gnt), 1);
        chk("rel b_gnt", 32'(b_gnt), 0);
        chk("rel a_rvalid", 32'(a_rvalid), 0);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        settle();
        chk("rel a_rdata", 32'(a_rdata), 32'hBEEF);
        tick();

        // B alone for 10 cycles, A arrives at cycle 5 and wins that cycle
        b_req = 1'b1; b_we = 1'b1; b_lock = 1'b0;
        for (int k = 0; k < 10; k++) begin
            b_addr = 6'(20 + k); b_wdata = 16'(k);
            a_req = (k == 5); a_we = 1'b1; a_addr = 6'd40; a_wdata = 16'h4040;
            settle();
            chk($sformatf("solo%0d b_gnt", k), 32'(b_gnt), 32'(k != 5));
            chk($sformatf("solo%0d a_gnt", k), 32'(a_gnt), 32'(k == 5));
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        settle();
        ram_idle("end");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter in front of the single-port 16-bit data RAM. It lets requester A (CPU load/store unit) and requester B (program loader / debug port) share the RAM. Each cycle it grants at most one access and drives the RAM command pins. It then returns read data to the owning requester one cycle later. A bounded lock lets one requester hold the RAM for read-modify-write sequences.

## Interface
- ADDR_W, 6, RAM address width
- DATA_W, 16, RAM data width
- LOCK_MAX, 4, max consecutive grants a locking requester keeps while the other is requesting (≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- a_req  in  1  A requests an access; held with fields stable until a_gnt
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  A address
- a_wdata  in  DATA_W  A write data
- a_lock  in  1  A requests to keep priority after this grant
- a_gnt  out  1  A access issued to RAM this cycle (combinational)
- a_rvalid  out  1  A read data valid (registered)
- a_rdata  out  DATA_W  A read data
- b_req, b_we, b_addr, b_wdata, b_lock, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- ram_add  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM write data
- ram_r_w  out  1  to RAM: 0 = read, 1 = write
- ram_enable  out  1  to RAM enable
- ram_ce  out  1  to RAM chip enable
- ram_data_out  in  DATA_W  from RAM, valid one cycle after a read is issued

## Operation
- State: prio (0 = A first, 1 = B first), lock_cnt (counts 0..LOCK_MAX-1), pend_a, pend_b.
- Winner selection each cycle:
  - Only one req high: that requester wins.
  - Both high: the requester named by prio wins.
  - Neither high: idle.
- Grant: gnt of the winner = 1, other gnt = 0. gnt is a same-cycle handshake: the access completes at this rising edge.
- RAM outputs on a grant: ram_add, ram_data_in and ram_r_w = winner's addr, wdata and we; ram_enable = ram_ce = 1.
- RAM outputs when idle or in reset: ram_add, ram_data_in, ram_r_w, ram_enable and ram_ce all 0.
- prio/lock update on a grant cycle:
  - Winner's lock = 1 and lock_cnt < LOCK_MAX-1: prio = winner, lock_cnt += 1.
  - Otherwise: prio = other requester, lock_cnt = 0.
- prio/lock update on an idle cycle: prio holds, lock_cnt = 0.
- Lone requester: always granted, every cycle, regardless of prio or lock.
- Read return:
  - On the grant edge, pend_x = winner_is_x & ~we. Both pend flags clear otherwise.
  - x_rvalid = pend_x. x_rdata = ram_data_out when pend_x, else 0.
- Writes: no response. A write is complete at the grant edge.
- Back-to-back accesses: a new grant is allowed in the same cycle as the previous read's rvalid, giving full throughput of 1 access/cycle.
- Read-after-write to the same address, even across requesters: returns the newly written data, because RAM order equals grant order.

## Timing
- Reset values (rst_n low, asynchronously): prio = 0, lock_cnt = 0, pend_a = pend_b = 0. All gnt, rvalid, rdata and ram_* outputs = 0 while rst_n is low.
- Grant latency: 0 cycles. gnt rises in the same cycle as req when the requester wins.
- Read latency: grant at edge N, rvalid high and rdata valid in cycle N+1 for exactly one cycle.
- Reset asserted mid-operation: a pending rvalid drops immediately and that read is lost. The requester must reissue after reset release.
- Reset release: the first grant is possible in the first cycle with rst_n high.
- Requester rules:
  - Fields may change only after gnt.
  - req may drop at any time without gnt; that is not an error and no access occurs.
- Simultaneous requests with lock: a locked winner gets at most LOCK_MAX consecutive grants. The other requester is then guaranteed the next grant.

## Test plan
- Reset then single A write addr 5 = 0x1234, then A read addr 5: a_gnt in the same cycle as each req; a_rvalid 1 cycle after the read grant with a_rdata = 0x1234; b_rvalid stays 0.
- A and B both request reads continuously from reset: grants alternate A, B, A, B…; each rvalid goes to the correct port one cycle after its grant; the RAM is busy every cycle.
- a_lock = 1, both requesting: A granted exactly LOCK_MAX = 4 cycles in a row, then B; lock_cnt returns to 0.
- A writes addr 3 = 0xBEEF, B reads addr 3 in the next cycle: b_rdata = 0xBEEF.
- rst_n pulsed low in the cycle after an A read grant: a_rvalid = 0 immediately; all ram_* = 0 during reset; prio = A after release.
- B alone with b_lock = 0 for 10 cycles: granted every cycle; A request arriving in cycle 5 wins next, since prio points to A after B's grant.
